// File: rtl/fp_sqrt_sigcalc_iter.sv
// fp_sqrt_sigcalc_iter: one-bit-per-cycle restoring square root of the significand, producing {root, guard, sticky}
module fp_sqrt_sigcalc_iter #(
   parameter int sig_width = 23
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 enable,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [sig_width-1:0] a_sig,
   input  logic                 a_exp_lsb,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [sig_width+2:0] z_sig_nr
);
   localparam int N  = sig_width + 2;
   localparam int CW = $clog2(N);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t            state_q;
   logic [2*N-1:0]    r_q;
   logic [N-1:0]      q_q, q_d;
   logic [N-1:0]      rem_q;
   logic [N+1:0]      rem_d, t, trial, diff;
   logic              borrow;
   logic [CW-1:0]     cnt_q;
   logic              in_ready_q, out_valid_q;
   logic [sig_width+2:0] z_q;
   // rem never exceeds N bits between iterations, so only the low N bits need storing
   always_comb begin
      t              = {rem_q, r_q[2*N-1 -: 2]};
      trial          = {q_q, 2'b01};
      {borrow, diff} = {1'b0, t} - {1'b0, trial};
      rem_d          = borrow ? t : diff;
      q_d            = {q_q[N-2:0], ~borrow};
   end
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= IDLE;
         r_q         <= '0;
         q_q         <= '0;
         rem_q       <= '0;
         cnt_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         z_q         <= '0;
      end else if (enable) begin
         case (state_q)
            IDLE: if (in_valid) begin
               r_q        <= a_exp_lsb ? {2'b01, a_sig, {(sig_width+2){1'b0}}}
                                       : {1'b1, a_sig, {(sig_width+3){1'b0}}};
               q_q        <= '0;
               rem_q      <= '0;
               cnt_q      <= '0;
               in_ready_q <= 1'b0;
               state_q    <= BUSY;
            end
            BUSY: begin
               r_q   <= r_q << 2;
               q_q   <= q_d;
               rem_q <= rem_d[N-1:0];
               if (cnt_q == CW'(N-1)) begin
                  z_q         <= {q_d, |rem_d};
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            DONE: if (out_ready) begin
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               state_q     <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign z_sig_nr  = z_q;
endmodule

// File: tb/tb_fp_sqrt_sigcalc_iter.sv
// tb_fp_sqrt_sigcalc_iter: scoreboard bench for the iterative significand square root
module tb_fp_sqrt_sigcalc_iter;
   localparam int SW = 23;
   logic          clk = 1'b0, resetn = 1'b0, enable = 1'b0, in_valid = 1'b0;
   logic          a_exp_lsb = 1'b0, out_ready = 1'b0;
   logic          in_ready, out_valid;
   logic [SW-1:0] a_sig = '0;
   logic [SW+2:0] z_sig_nr;
   logic [SW+2:0] exp_q[$];
   int            total = 0, bad = 0;

   fp_sqrt_sigcalc_iter #(.sig_width(SW)) dut (
      .clk(clk), .resetn(resetn), .enable(enable), .in_valid(in_valid),
      .in_ready(in_ready), .a_sig(a_sig), .a_exp_lsb(a_exp_lsb),
      .out_valid(out_valid), .out_ready(out_ready), .z_sig_nr(z_sig_nr)
   );

   always #5 clk = ~clk;

   // reference: largest q with q*q <= R by binary search, sticky when not exact
   function automatic logic [25:0] model(input logic [22:0] s, input logic l);
      longint unsigned r, lo, hi, mid;
      r  = l ? 64'({2'b01, s, 25'b0}) : 64'({1'b1, s, 26'b0});
      lo = 0;
      hi = 64'd1 << 26;
      while (hi - lo > 1) begin
         mid = (lo + hi) >> 1;
         if (mid * mid <= r) lo = mid; else hi = mid;
      end
      return {lo[24:0], lo * lo != r};
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [22:0] s, input logic l, input logic [25:0] e);
      int w = 0;
      a_sig = s; a_exp_lsb = l; in_valid = 1'b1; enable = 1'b1;
      while (!in_ready && w < 100) begin cyc(); w++; end
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL issue_ready: in_ready=%b want 1", in_ready); end
      cyc();
      in_valid = 1'b0;
      exp_q.push_back(e);
   endtask

   task automatic wait_out(output int c);
      c = 0;
      while (!out_valid && c < 200) begin cyc(); c++; end
   endtask

   task automatic test_reset();
      resetn = 1'b0; enable = 1'b1; in_valid = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      total++; if (z_sig_nr !== 26'h0) begin bad++; $display("FAIL reset_z: got %h want 0", z_sig_nr); end
      in_valid = 1'b0; resetn = 1'b1;
      cyc();
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL post_reset_out_valid: got %b want 0", out_valid); end
   endtask

   task automatic test_directed();
      logic [22:0] sigs[3] = '{23'h0, 23'h0, 23'h100000};
      logic        lsbs[3] = '{1'b1, 1'b0, 1'b0};
      logic [25:0] exps[3] = '{26'h2000000, 26'h2D413CD, 26'h3000000};
      logic [25:0] e;
      int c;
      for (int i = 0; i < 3; i++) begin
         issue(sigs[i], lsbs[i], exps[i]);
         wait_out(c);
         total++; if (c != 25) begin bad++; $display("FAIL dir%0d_latency: got %0d want 25", i, c); end
         e = exp_q.pop_front();
         total++; if (z_sig_nr !== e) begin bad++; $display("FAIL dir%0d_z: got %h want %h", i, z_sig_nr, e); end
         total++; if (model(sigs[i], lsbs[i]) !== e) begin bad++; $display("FAIL dir%0d_model: got %h want %h", i, model(sigs[i], lsbs[i]), e); end
         out_ready = 1'b1;
         cyc();
         out_ready = 1'b0;
         total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL dir%0d_handshake: out_valid=%b in_ready=%b want 0 1", i, out_valid, in_ready); end
      end
   endtask

   task automatic test_backpressure();
      logic [25:0] e;
      int c;
      issue(23'h0, 1'b1, 26'h2000000);
      wait_out(c);
      e = exp_q.pop_front();
      a_sig = 23'h7FFFFF; a_exp_lsb = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         cyc();
         total++; if (out_valid !== 1'b1 || z_sig_nr !== e) begin bad++; $display("FAIL bp_hold%0d: out_valid=%b z=%h want 1 %h", i, out_valid, z_sig_nr, e); end
      end
      in_valid = 1'b0; out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;
      total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL bp_release: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid); end
      cyc();
      total++; if (in_ready !== 1'b1 || z_sig_nr !== e) begin bad++; $display("FAIL bp_not_taken: in_ready=%b z=%h want 1 %h", in_ready, z_sig_nr, e); end
   endtask

   task automatic test_stall();
      logic [25:0] e;
      int c;
      issue(23'h0, 1'b0, 26'h2D413CD);
      repeat (5) cyc();
      enable = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cyc();
         total++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin bad++; $display("FAIL stall_busy%0d: out_valid=%b in_ready=%b want 0 0", i, out_valid, in_ready); end
      end
      enable = 1'b1;
      wait_out(c);
      total++; if (10 + c != 30) begin bad++; $display("FAIL stall_latency: got %0d want 30", 10 + c); end
      e = exp_q.pop_front();
      total++; if (z_sig_nr !== e) begin bad++; $display("FAIL stall_z: got %h want %h", z_sig_nr, e); end
      out_ready = 1'b1; enable = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stall_done%0d: out_valid=%b want 1", i, out_valid); end
      end
      enable = 1'b1;
      cyc();
      out_ready = 1'b0;
      total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL stall_release: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready); end
      enable = 1'b0; in_valid = 1'b1;
      repeat (3) cyc();
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stall_idle_accept: in_ready=%b want 1", in_ready); end
      in_valid = 1'b0; enable = 1'b1;
   endtask

   task automatic test_reset_mid();
      logic [25:0] e;
      int c;
      issue(23'h100000, 1'b0, 26'h3000000);
      repeat (12) cyc();
      resetn = 1'b0;
      #1;
      total++; if (out_valid !== 1'b0 || z_sig_nr !== 26'h0 || in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_during: out_valid=%b z=%h in_ready=%b want 0 0 1", out_valid, z_sig_nr, in_ready); end
      cyc();
      resetn = 1'b1;
      exp_q.delete();
      cyc();
      total++; if (out_valid !== 1'b0 || z_sig_nr !== 26'h0 || in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_after: out_valid=%b z=%h in_ready=%b want 0 0 1", out_valid, z_sig_nr, in_ready); end
      issue(23'h0, 1'b1, 26'h2000000);
      wait_out(c);
      total++; if (c != 25) begin bad++; $display("FAIL rstmid_latency: got %0d want 25", c); end
      e = exp_q.pop_front();
      total++; if (z_sig_nr !== e) begin bad++; $display("FAIL rstmid_z: got %h want %h", z_sig_nr, e); end
      out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;
   endtask

   task automatic test_random();
      logic [22:0] s;
      logic        l, acc, done;
      logic [25:0] e;
      int          w;
      for (int i = 0; i < 1000; i++) begin
         s = 23'($urandom); l = 1'($urandom);
         a_sig = s; a_exp_lsb = l; in_valid = 1'b1; acc = 1'b0; w = 0;
         while (!acc && w < 200) begin
            enable = ($urandom_range(0, 3) != 0);
            acc = in_ready && enable;
            cyc(); w++;
         end
         total++; if (acc !== 1'b1) begin bad++; $display("FAIL rnd%0d_accept: accepted=%b want 1", i, acc); break; end
         exp_q.push_back(model(s, l));
         done = 1'b0; w = 0;
         while (!done && w < 400) begin
            enable = ($urandom_range(0, 3) != 0);
            out_ready = 1'($urandom); in_valid = 1'($urandom);
            a_sig = 23'($urandom); a_exp_lsb = 1'($urandom);
            if (out_valid && out_ready && enable) begin
               e = exp_q.pop_front();
               total++; if (z_sig_nr !== e) begin bad++; $display("FAIL rnd%0d_z: sig=%h lsb=%b got %h want %h", i, s, l, z_sig_nr, e); end
               done = 1'b1;
            end
            cyc(); w++;
         end
         in_valid = 1'b0; out_ready = 1'b0;
         total++; if (done !== 1'b1) begin bad++; $display("FAIL rnd%0d_timeout: done=%b want 1", i, done); break; end
      end
      enable = 1'b1;
   endtask

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      test_stall();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
